// File: rtl/alu_rpn_pila_if.sv
// Command/result bundle for the RPN calculator core: the keypad side drives
// commands (master), the core answers with stack view and status (slave).
interface alu_rpn_pila_if #(
  parameter int N_BITS = 8,
  parameter int DEPTH  = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic              in_valid;
  logic [1:0]        cmd;
  logic [2:0]        operacion;
  logic [N_BITS-1:0] dato_in;
  logic              out_valid;
  logic [N_BITS-1:0] tope;
  logic [CW-1:0]     cuenta;
  logic [3:0]        flags;
  logic              error;
  logic [1:0]        err_code;

  modport master (
    output in_valid, cmd, operacion, dato_in,
    input  out_valid, tope, cuenta, flags, error, err_code
  );

  modport slave (
    input  in_valid, cmd, operacion, dato_in,
    output out_valid, tope, cuenta, flags, error, err_code
  );
endinterface

// File: rtl/alu_rpn_pila.sv
// RPN calculator core: N_BITS ALU fused with a DEPTH-entry operand stack.
// Optional macro ALU_RPN_MUL_EN enables operacion 101 (MUL); otherwise 101 is illegal.
module alu_rpn_pila #(
  parameter int N_BITS = 8,
  parameter int DEPTH  = 4
) (
  input logic           clk,
  input logic           reset,
  alu_rpn_pila_if.slave bus
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int IW  = $clog2(DEPTH);
  localparam int MSB = N_BITS - 1;

  localparam logic [1:0] CMD_PUSH  = 2'b00;
  localparam logic [1:0] CMD_OP    = 2'b01;
  localparam logic [1:0] CMD_POP   = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OVER  = 2'b01;
  localparam logic [1:0] ERR_UNDER = 2'b10;
  localparam logic [1:0] ERR_ILLEG = 2'b11;

  logic [N_BITS-1:0] stack_reg [DEPTH];
  logic [CW-1:0]     cuenta_reg, cuenta_next;
  logic [3:0]        flags_reg, flags_next;
  logic              out_valid_reg, out_valid_next;
  logic              error_reg, error_next;
  logic [1:0]        err_code_reg, err_code_next;

  logic              write_req;
  logic [IW-1:0]     wr_idx;
  logic [N_BITS-1:0] wr_data;
  logic [DEPTH-1:0]  wr_en;

  logic [IW-1:0]     idx_a, idx_b;
  logic [N_BITS-1:0] operand_a, operand_b;

  logic [N_BITS:0]   sum_ext;
  logic [N_BITS-1:0] alu_res;
  logic              alu_c, alu_v, op_legal;

  // Index arithmetic wraps when cuenta is too small; those reads are never used.
  assign idx_b     = IW'(cuenta_reg - CW'(1));
  assign idx_a     = IW'(cuenta_reg - CW'(2));
  assign operand_a = stack_reg[idx_a];
  assign operand_b = stack_reg[idx_b];

`ifdef ALU_RPN_MUL_EN
  logic [2*N_BITS-1:0] mul_full;
  assign mul_full = {{N_BITS{1'b0}}, operand_a} * {{N_BITS{1'b0}}, operand_b};
`endif

  always_comb begin
    sum_ext  = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    op_legal = 1'b1;
    case (bus.operacion)
      3'b000: begin
        sum_ext = {1'b0, operand_a} + {1'b0, operand_b};
        alu_res = sum_ext[N_BITS-1:0];
        alu_c   = sum_ext[N_BITS];
        alu_v   = (operand_a[MSB] == operand_b[MSB]) && (alu_res[MSB] != operand_a[MSB]);
      end
      3'b001: begin
        // Two's-complement subtract: carry out set means no borrow.
        sum_ext = {1'b0, operand_a} + {1'b0, ~operand_b} + (N_BITS + 1)'(1);
        alu_res = sum_ext[N_BITS-1:0];
        alu_c   = sum_ext[N_BITS];
        alu_v   = (operand_a[MSB] != operand_b[MSB]) && (alu_res[MSB] != operand_a[MSB]);
      end
      3'b010: alu_res = operand_a & operand_b;
      3'b011: alu_res = operand_a | operand_b;
      3'b100: alu_res = operand_a ^ operand_b;
`ifdef ALU_RPN_MUL_EN
      3'b101: begin
        alu_res = mul_full[N_BITS-1:0];
        alu_c   = |mul_full[2*N_BITS-1:N_BITS];
        alu_v   = alu_c;
      end
`endif
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    cuenta_next    = cuenta_reg;
    flags_next     = flags_reg;
    out_valid_next = bus.in_valid;
    error_next     = 1'b0;
    err_code_next  = ERR_NONE;
    write_req      = 1'b0;
    wr_idx         = idx_a;
    wr_data        = alu_res;
    if (bus.in_valid) begin
      case (bus.cmd)
        CMD_PUSH: begin
          if (cuenta_reg == CW'(DEPTH)) begin
            error_next    = 1'b1;
            err_code_next = ERR_OVER;
          end else begin
            write_req   = 1'b1;
            wr_idx      = IW'(cuenta_reg);
            wr_data     = bus.dato_in;
            cuenta_next = cuenta_reg + CW'(1);
          end
        end
        CMD_OP: begin
          // Underflow takes precedence over an illegal opcode.
          if (cuenta_reg < CW'(2)) begin
            error_next    = 1'b1;
            err_code_next = ERR_UNDER;
          end else if (!op_legal) begin
            error_next    = 1'b1;
            err_code_next = ERR_ILLEG;
          end else begin
            write_req   = 1'b1;
            cuenta_next = cuenta_reg - CW'(1);
            flags_next  = {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
          end
        end
        CMD_POP: begin
          if (cuenta_reg == '0) begin
            error_next    = 1'b1;
            err_code_next = ERR_UNDER;
          end else begin
            cuenta_next = cuenta_reg - CW'(1);
          end
        end
        CMD_CLEAR: begin
          cuenta_next = '0;
          flags_next  = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta_reg    <= '0;
      flags_reg     <= '0;
      out_valid_reg <= 1'b0;
      error_reg     <= 1'b0;
      err_code_reg  <= ERR_NONE;
    end else begin
      cuenta_reg    <= cuenta_next;
      flags_reg     <= flags_next;
      out_valid_reg <= out_valid_next;
      error_reg     <= error_next;
      err_code_reg  <= err_code_next;
    end
  end

  // Stack storage needs no reset: cuenta alone defines which entries are live.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stack
    assign wr_en[gi] = write_req && !reset && (wr_idx == IW'(gi));
    always_ff @(posedge clk) begin
      if (wr_en[gi]) begin
        stack_reg[gi] <= wr_data;
      end
    end
  end

  assign bus.tope      = (cuenta_reg == '0) ? '0 : operand_b;
  assign bus.cuenta    = cuenta_reg;
  assign bus.flags     = flags_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.error     = error_reg;
  assign bus.err_code  = err_code_reg;
endmodule

// File: tb/tb_alu_rpn_pila.sv
// Directed self-checking bench for alu_rpn_pila (N_BITS=8, DEPTH=4).
module tb_alu_rpn_pila;
  localparam int N_BITS = 8;
  localparam int DEPTH  = 4;

  localparam logic [1:0] PUSH  = 2'b00;
  localparam logic [1:0] OP    = 2'b01;
  localparam logic [1:0] POP   = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_rpn_pila_if #(.N_BITS(N_BITS), .DEPTH(DEPTH)) bus ();

  alu_rpn_pila #(.N_BITS(N_BITS), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Issue one command for exactly one cycle; outputs are valid on return.
  task automatic send(input logic [1:0] c, input logic [2:0] op, input logic [7:0] d);
    bus.in_valid  = 1'b1;
    bus.cmd       = c;
    bus.operacion = op;
    bus.dato_in   = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    $display("cmd=%b op=%b dato=%h -> ov=%b err=%b code=%b tope=%h cuenta=%0d flags=%b",
             c, op, d, bus.out_valid, bus.error, bus.err_code, bus.tope, bus.cuenta, bus.flags);
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.cmd       = PUSH;
    bus.operacion = 3'b000;
    bus.dato_in   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    $display("reset idle: cuenta=%0d tope=%h flags=%b ov=%b", bus.cuenta, bus.tope, bus.flags, bus.out_valid);
    checks++; if (bus.cuenta !== 3'd0) begin errors++; $display("FAIL reset_cuenta got %0d want 0", bus.cuenta); end
    checks++; if (bus.tope !== 8'h00) begin errors++; $display("FAIL reset_tope got %h want 00", bus.tope); end
    checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", bus.flags); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.error !== 1'b0 || bus.err_code !== 2'b00) begin errors++; $display("FAIL reset_error got %b/%b want 0/00", bus.error, bus.err_code); end
  endtask

  task automatic test_sub();
    send(PUSH, 3'b000, 8'h05);
    checks++; if (bus.out_valid !== 1'b1 || bus.tope !== 8'h05) begin errors++; $display("FAIL sub_push got ov=%b tope=%h want 1/05", bus.out_valid, bus.tope); end
    send(PUSH, 3'b000, 8'h03);
    send(OP, 3'b001, 8'h00);
    checks++; if (bus.tope !== 8'h02) begin errors++; $display("FAIL sub_tope got %h want 02", bus.tope); end
    checks++; if (bus.cuenta !== 3'd1) begin errors++; $display("FAIL sub_cuenta got %0d want 1", bus.cuenta); end
    checks++; if (bus.flags !== 4'b0010) begin errors++; $display("FAIL sub_flags got %b want 0010", bus.flags); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL sub_error got %b want 0", bus.error); end
    send(CLEAR, 3'b000, 8'h00);
    checks++; if (bus.cuenta !== 3'd0 || bus.flags !== 4'b0000 || bus.tope !== 8'h00) begin errors++; $display("FAIL clear got cuenta=%0d flags=%b tope=%h want 0/0000/00", bus.cuenta, bus.flags, bus.tope); end
  endtask

  task automatic test_add_overflow();
    send(PUSH, 3'b000, 8'h7F);
    send(PUSH, 3'b000, 8'h01);
    send(OP, 3'b000, 8'h00);
    checks++; if (bus.tope !== 8'h80) begin errors++; $display("FAIL add_tope got %h want 80", bus.tope); end
    checks++; if (bus.flags !== 4'b1001) begin errors++; $display("FAIL add_flags got %b want 1001", bus.flags); end
    checks++; if (bus.cuenta !== 3'd1) begin errors++; $display("FAIL add_cuenta got %0d want 1", bus.cuenta); end
  endtask

  task automatic test_push_overflow();
    send(CLEAR, 3'b000, 8'h00);
    for (int i = 1; i <= 4; i++) send(PUSH, 3'b000, 8'(i));
    send(PUSH, 3'b000, 8'hAA);
    checks++; if (bus.error !== 1'b1 || bus.err_code !== 2'b01) begin errors++; $display("FAIL push_ovf_err got %b/%b want 1/01", bus.error, bus.err_code); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL push_ovf_ov got %b want 1", bus.out_valid); end
    checks++; if (bus.cuenta !== 3'd4 || bus.tope !== 8'h04) begin errors++; $display("FAIL push_ovf_state got cuenta=%0d tope=%h want 4/04", bus.cuenta, bus.tope); end
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.error !== 1'b0 || bus.err_code !== 2'b00) begin errors++; $display("FAIL pulse_clear got ov=%b err=%b code=%b want 0/0/00", bus.out_valid, bus.error, bus.err_code); end
    send(POP, 3'b000, 8'h00);
    checks++; if (bus.cuenta !== 3'd3 || bus.tope !== 8'h03) begin errors++; $display("FAIL pop got cuenta=%0d tope=%h want 3/03", bus.cuenta, bus.tope); end
  endtask

  task automatic test_underflow_illegal();
    send(CLEAR, 3'b000, 8'h00);
    send(OP, 3'b000, 8'h00);
    checks++; if (bus.error !== 1'b1 || bus.err_code !== 2'b10) begin errors++; $display("FAIL op_underflow got %b/%b want 1/10", bus.error, bus.err_code); end
    send(POP, 3'b000, 8'h00);
    checks++; if (bus.error !== 1'b1 || bus.err_code !== 2'b10 || bus.cuenta !== 3'd0) begin errors++; $display("FAIL pop_underflow got %b/%b cuenta=%0d want 1/10/0", bus.error, bus.err_code, bus.cuenta); end
    send(PUSH, 3'b000, 8'h0F);
    send(OP, 3'b111, 8'h00);
    checks++; if (bus.err_code !== 2'b10) begin errors++; $display("FAIL underflow_before_illegal got %b want 10", bus.err_code); end
    send(PUSH, 3'b000, 8'hF0);
    send(OP, 3'b110, 8'h00);
    checks++; if (bus.error !== 1'b1 || bus.err_code !== 2'b11 || bus.cuenta !== 3'd2) begin errors++; $display("FAIL illegal_110 got %b/%b cuenta=%0d want 1/11/2", bus.error, bus.err_code, bus.cuenta); end
    send(OP, 3'b111, 8'h00);
    checks++; if (bus.err_code !== 2'b11 || bus.tope !== 8'hF0 || bus.flags !== 4'b0000) begin errors++; $display("FAIL illegal_111 got code=%b tope=%h flags=%b want 11/F0/0000", bus.err_code, bus.tope, bus.flags); end
    send(OP, 3'b100, 8'h00);
    checks++; if (bus.tope !== 8'hFF || bus.flags !== 4'b1000 || bus.cuenta !== 3'd1) begin errors++; $display("FAIL xor got tope=%h flags=%b cuenta=%0d want FF/1000/1", bus.tope, bus.flags, bus.cuenta); end
  endtask

  task automatic test_mul();
    send(CLEAR, 3'b000, 8'h00);
    send(PUSH, 3'b000, 8'h10);
    send(PUSH, 3'b000, 8'h10);
    send(OP, 3'b101, 8'h00);
`ifdef ALU_RPN_MUL_EN
    checks++; if (bus.error !== 1'b0 || bus.tope !== 8'h00 || bus.cuenta !== 3'd1) begin errors++; $display("FAIL mul got err=%b tope=%h cuenta=%0d want 0/00/1", bus.error, bus.tope, bus.cuenta); end
    checks++; if (bus.flags !== 4'b0111) begin errors++; $display("FAIL mul_flags got %b want 0111", bus.flags); end
`else
    checks++; if (bus.error !== 1'b1 || bus.err_code !== 2'b11) begin errors++; $display("FAIL mul_disabled got %b/%b want 1/11", bus.error, bus.err_code); end
    checks++; if (bus.cuenta !== 3'd2 || bus.tope !== 8'h10) begin errors++; $display("FAIL mul_disabled_state got cuenta=%0d tope=%h want 2/10", bus.cuenta, bus.tope); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [1:0] v_cmd   [10] = '{CLEAR, PUSH, PUSH, OP, PUSH, OP, PUSH, OP, PUSH, OP};
    logic [2:0] v_op    [10] = '{3'd0, 3'd0, 3'd0, 3'b010, 3'd0, 3'b011, 3'd0, 3'b001, 3'd0, 3'b000};
    logic [7:0] v_dato  [10] = '{8'h00, 8'h0C, 8'h0A, 8'h00, 8'h03, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00};
    logic [7:0] e_tope  [10] = '{8'h00, 8'h0C, 8'h0A, 8'h08, 8'h03, 8'h0B, 8'h0C, 8'hFF, 8'h01, 8'h00};
    logic [2:0] e_cnt   [10] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1};
    logic [3:0] e_flags [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0110};
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = 1'b1;
      bus.cmd       = v_cmd[i];
      bus.operacion = v_op[i];
      bus.dato_in   = v_dato[i];
      @(posedge clk);
      #1;
      $display("b2b %0d: ov=%b tope=%h cuenta=%0d flags=%b", i, bus.out_valid, bus.tope, bus.cuenta, bus.flags);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.error !== 1'b0 || bus.tope !== e_tope[i] ||
          bus.cuenta !== e_cnt[i] || bus.flags !== e_flags[i]) begin
        errors++;
        $display("FAIL b2b_%0d got ov=%b err=%b tope=%h cuenta=%0d flags=%b want 1/0/%h/%0d/%b",
                 i, bus.out_valid, bus.error, bus.tope, bus.cuenta, bus.flags, e_tope[i], e_cnt[i], e_flags[i]);
      end
    end
    bus.in_valid = 1'b0;
    send(PUSH, 3'b000, 8'h01);
    send(OP, 3'b000, 8'h00);
    send(PUSH, 3'b000, 8'h80);
    send(PUSH, 3'b000, 8'h01);
    send(OP, 3'b001, 8'h00);
    checks++; if (bus.tope !== 8'h7F || bus.flags !== 4'b0011 || bus.cuenta !== 3'd2) begin errors++; $display("FAIL sub_ovf got tope=%h flags=%b cuenta=%0d want 7F/0011/2", bus.tope, bus.flags, bus.cuenta); end
  endtask

  task automatic test_reset_priority();
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.cmd       = PUSH;
    bus.dato_in   = 8'h55;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.cuenta !== 3'd0 || bus.tope !== 8'h00 || bus.out_valid !== 1'b0 || bus.flags !== 4'b0000) begin errors++; $display("FAIL reset_priority got cuenta=%0d tope=%h ov=%b flags=%b want 0/00/0/0000", bus.cuenta, bus.tope, bus.out_valid, bus.flags); end
    send(PUSH, 3'b000, 8'h33);
    checks++; if (bus.cuenta !== 3'd1 || bus.tope !== 8'h33) begin errors++; $display("FAIL after_reset_push got cuenta=%0d tope=%h want 1/33", bus.cuenta, bus.tope); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sub();
    test_add_overflow();
    test_push_overflow();
    test_underflow_illegal();
    test_mul();
    test_back_to_back();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
